// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and control-output bundle between the UART RX FIFO, the command
// parser and the clock/stopwatch/sensor control logic.
interface uart_cmd_parser_if #(
    parameter int NUM_DIGITS = 6
);
    logic [7:0]              iRx_Data;
    logic                    iRx_Empty;
    logic                    oRx_Pop;
    logic                    oSet;
    logic [4:0]              oMode;
    logic                    oBtn_U;
    logic                    oBtn_D;
    logic                    oBtn_L;
    logic                    oBtn_R;
    logic                    oTime_En;
    logic                    oLoad;
    logic [4*NUM_DIGITS-1:0] oLoad_Bcd;
    logic                    oErr;
    logic                    oBusy;

    modport master (
        output iRx_Data, iRx_Empty,
        input  oRx_Pop, oSet, oMode, oBtn_U, oBtn_D, oBtn_L, oBtn_R,
        input  oTime_En, oLoad, oLoad_Bcd, oErr, oBusy
    );

    modport slave (
        input  iRx_Data, iRx_Empty,
        output oRx_Pop, oSet, oMode, oBtn_U, oBtn_D, oBtn_L, oBtn_R,
        output oTime_En, oLoad, oLoad_Bcd, oErr, oBusy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART command parser: single-letter mode/set/button commands plus '#'-prefixed BCD entry.
// Optional entry idle timeout is built only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_parser #(
    parameter int NUM_DIGITS  = 6,
    parameter int BTN_PULSE   = 1,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic              iClk,
    input  logic              iRst,
    uart_cmd_parser_if.slave  bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int BTN_W = (BTN_PULSE > 1) ? $clog2(BTN_PULSE) : 1;
    localparam logic [CNT_W-1:0] DIG_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [BTN_W-1:0] BTN_LAST = BTN_W'(BTN_PULSE - 1);
`ifdef UART_CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ENTRY = 1'b1
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    state_t             state_r,    state_nxt_s;
    logic [3:0]         mode_r,     mode_nxt_s;
    logic               fnd_r,      fnd_nxt_s;
    logic               set_r,      set_nxt_s;
    logic [3:0]         btn_r,      btn_nxt_s;      // {U, D, L, R}
    logic [BTN_W-1:0]   btn_cnt_r,  btn_cnt_nxt_s;
    logic               ten_r,      ten_nxt_s;
    logic               load_r,     load_nxt_s;
    logic               err_r,      err_nxt_s;
    logic               busy_r;
    logic [BCD_W-1:0]   bcd_r,      bcd_nxt_s;
    logic [BCD_W-1:0]   shreg_r,    shreg_nxt_s;
    logic [CNT_W-1:0]   dcnt_r,     dcnt_nxt_s;
    logic [BCD_W+3:0]   shift_s;
    logic               byte_vld_s;
    logic [7:0]         rx_byte_s;
`ifdef UART_CMD_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_r,   to_cnt_nxt_s;
`endif

    // The parser never stalls, so the FIFO is popped whenever it has data.
    assign byte_vld_s  = ~bus.iRx_Empty;
    assign rx_byte_s   = bus.iRx_Data;
    assign bus.oRx_Pop = byte_vld_s;
    assign shift_s     = {shreg_r, rx_byte_s[3:0]};

    assign bus.oMode     = {mode_r, fnd_r};
    assign bus.oSet      = set_r;
    assign bus.oBtn_U    = btn_r[3];
    assign bus.oBtn_D    = btn_r[2];
    assign bus.oBtn_L    = btn_r[1];
    assign bus.oBtn_R    = btn_r[0];
    assign bus.oTime_En  = ten_r;
    assign bus.oLoad     = load_r;
    assign bus.oLoad_Bcd = bcd_r;
    assign bus.oErr      = err_r;
    assign bus.oBusy     = busy_r;

    // Next-state and next-output decode for the consumed byte.
    always_comb begin
        state_nxt_s   = state_r;
        mode_nxt_s    = mode_r;
        fnd_nxt_s     = fnd_r;
        set_nxt_s     = set_r;
        btn_nxt_s     = btn_r;
        btn_cnt_nxt_s = btn_cnt_r;
        ten_nxt_s     = 1'b0;
        load_nxt_s    = 1'b0;
        err_nxt_s     = 1'b0;
        bcd_nxt_s     = bcd_r;
        shreg_nxt_s   = shreg_r;
        dcnt_nxt_s    = dcnt_r;
`ifdef UART_CMD_TIMEOUT_EN
        to_cnt_nxt_s  = {TO_W{1'b0}};
`endif

        // An active pulse runs down here; a new button byte below overrides it.
        if (btn_r != 4'b0000) begin
            if (btn_cnt_r == {BTN_W{1'b0}}) begin
                btn_nxt_s = 4'b0000;
            end else begin
                btn_cnt_nxt_s = btn_cnt_r - {{(BTN_W-1){1'b0}}, 1'b1};
            end
        end else begin
            btn_cnt_nxt_s = {BTN_W{1'b0}};
        end

        case (state_r)
            ST_IDLE: begin
                if (byte_vld_s) begin
                    case (rx_byte_s)
                        8'h43: mode_nxt_s = 4'b0000;                 // 'C'
                        8'h57: mode_nxt_s = 4'b0001;                 // 'W'
                        8'h54: mode_nxt_s = 4'b0010;                 // 'T'
                        8'h55: mode_nxt_s = 4'b0100;                 // 'U'
                        8'h44: mode_nxt_s = 4'b1000;                 // 'D'
                        8'h4D: fnd_nxt_s  = ~fnd_r;                  // 'M'
                        8'h53: set_nxt_s  = ~set_r;                  // 'S'
                        8'h75: begin btn_nxt_s = 4'b1000; btn_cnt_nxt_s = BTN_LAST; end
                        8'h64: begin btn_nxt_s = 4'b0100; btn_cnt_nxt_s = BTN_LAST; end
                        8'h6C: begin btn_nxt_s = 4'b0010; btn_cnt_nxt_s = BTN_LAST; end
                        8'h72: begin btn_nxt_s = 4'b0001; btn_cnt_nxt_s = BTN_LAST; end
                        8'h58: ten_nxt_s  = 1'b1;                    // 'X'
                        8'h23: begin                                 // '#'
                            state_nxt_s = ST_ENTRY;
                            dcnt_nxt_s  = {CNT_W{1'b0}};
                            shreg_nxt_s = {BCD_W{1'b0}};
                        end
                        default: ;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_ENTRY: begin
                if (byte_vld_s) begin
                    if (is_digit(rx_byte_s)) begin
                        if (dcnt_r < DIG_FULL) begin
                            shreg_nxt_s = shift_s[BCD_W-1:0];
                            dcnt_nxt_s  = dcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            err_nxt_s   = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        case (rx_byte_s)
                            8'h0D, 8'h0A: begin
                                if (dcnt_r == DIG_FULL) begin
                                    bcd_nxt_s  = shreg_r;
                                    load_nxt_s = 1'b1;
                                end else begin
                                    err_nxt_s  = 1'b1;
                                end
                                state_nxt_s = ST_IDLE;
                            end
                            8'h1B:   state_nxt_s = ST_IDLE;
                            default: begin
                                err_nxt_s   = 1'b1;
                                state_nxt_s = ST_IDLE;
                            end
                        endcase
                    end
                end else begin
`ifdef UART_CMD_TIMEOUT_EN
                    // A byte on the terminal-count edge takes the branch above instead.
                    if (to_cnt_r == TO_LAST) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        to_cnt_nxt_s = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_nxt_s = ST_ENTRY;
`endif
                end
            end

            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r   <= ST_IDLE;
            mode_r    <= 4'b0000;
            fnd_r     <= 1'b0;
            set_r     <= 1'b0;
            btn_r     <= 4'b0000;
            btn_cnt_r <= {BTN_W{1'b0}};
            ten_r     <= 1'b0;
            load_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            bcd_r     <= {BCD_W{1'b0}};
            shreg_r   <= {BCD_W{1'b0}};
            dcnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            mode_r    <= mode_nxt_s;
            fnd_r     <= fnd_nxt_s;
            set_r     <= set_nxt_s;
            btn_r     <= btn_nxt_s;
            btn_cnt_r <= btn_cnt_nxt_s;
            ten_r     <= ten_nxt_s;
            load_r    <= load_nxt_s;
            err_r     <= err_nxt_s;
            busy_r    <= (state_nxt_s == ST_ENTRY);
            bcd_r     <= bcd_nxt_s;
            shreg_r   <= shreg_nxt_s;
            dcnt_r    <= dcnt_nxt_s;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    // Idle-clock counter for an open entry; cleared by every consumed byte.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_nxt_s;
        end
    end
`endif
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed bytes push expected output
// changes (stamped with their clock number) and a monitor compares them.
module tb_uart_cmd_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_parser_if #(.NUM_DIGITS(6)) bus();

    uart_cmd_parser #(
        .NUM_DIGITS(6),
        .BTN_PULSE(3),
        .TIMEOUT_CYC(50)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .bus(bus)
    );

    typedef struct packed {
        int          c;
        logic [4:0]  mode;
        logic        set;
        logic [3:0]  btn;   // {U, D, L, R}
        logic        ten;
        logic        load;
        logic        err;
        logic        busy;
        logic [23:0] bcd;
    } snap_t;

    snap_t      exp_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    int         last   = 0;
    int         t_ref  = 0;
    bit         mon_en = 1'b0;
    logic [4:0]  e_mode = 5'b00000;
    logic        e_set  = 1'b0;
    logic        e_busy = 1'b0;
    logic [23:0] e_bcd  = 24'h000000;

    function automatic snap_t sample();
        snap_t s;
        s.c    = cyc;
        s.mode = bus.oMode;
        s.set  = bus.oSet;
        s.btn  = {bus.oBtn_U, bus.oBtn_D, bus.oBtn_L, bus.oBtn_R};
        s.ten  = bus.oTime_En;
        s.load = bus.oLoad;
        s.err  = bus.oErr;
        s.busy = bus.oBusy;
        s.bcd  = bus.oLoad_Bcd;
        return s;
    endfunction

    task automatic push(input int c, input logic [3:0] btn, input logic ten,
                        input logic load, input logic err);
        snap_t s;
        s.c = c; s.mode = e_mode; s.set = e_set; s.btn = btn; s.ten = ten;
        s.load = load; s.err = err; s.busy = e_busy; s.bcd = e_bcd;
        exp_q.push_back(s);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.iRx_Data  = b;
        bus.iRx_Empty = 1'b0;
        last = cyc + 1;
        #1;
        n_vec++;
        if (bus.oRx_Pop !== 1'b1) begin
            n_miss++;
            $display("FAIL pop_high byte=%h got=%b exp=1", b, bus.oRx_Pop);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.iRx_Empty = 1'b1;
            bus.iRx_Data  = 8'h00;
        end
        #1;
        n_vec++;
        if (bus.oRx_Pop !== 1'b0) begin
            n_miss++;
            $display("FAIL pop_low got=%b exp=0", bus.oRx_Pop);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        while (exp_q.size() != 0) begin
            snap_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL missing_event exp=%h", e);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t rs;
        int    e2;
        bus.iRx_Data  = 8'h00;
        bus.iRx_Empty = 1'b1;

        fork
            begin : monitor
                snap_t act, cur, prev, e;
                prev = '0;
                forever begin
                    @(posedge clk);
                    #1;
                    act = sample();
                    cur = act;
                    cur.c = 0;
                    if (mon_en && cur !== prev) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_miss++;
                            $display("FAIL unexpected_event got=%h", act);
                        end else begin
                            e = exp_q.pop_front();
                            if (act !== e) begin
                                n_miss++;
                                $display("FAIL out_event got=%h exp=%h", act, e);
                            end
                        end
                    end
                    prev = cur;
                end
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        rs = sample();
        rs.c = 0;
        n_vec++;
        if (rs !== '0 || bus.oRx_Pop !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state got=%h pop=%b exp=0", rs, bus.oRx_Pop);
        end
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Mode / FND / set on consecutive clocks
        send(8'h54); e_mode = 5'b00100; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(8'h4D); e_mode = 5'b00101; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(8'h53); e_set  = 1'b1;     push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // 'u' restarted by 'l' two clocks later
        send(8'h75); push(last, 4'b1000, 1'b0, 1'b0, 1'b0);
        idle(1);
        send(8'h6C); push(last, 4'b0010, 1'b0, 1'b0, 1'b0);
        push(last + 3, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Non-button byte during a 'd' pulse, then a lone 'r'
        send(8'h64); t_ref = last; push(last, 4'b0100, 1'b0, 1'b0, 1'b0);
        send(8'h4D); e_mode = 5'b00100; push(last, 4'b0100, 1'b0, 1'b0, 1'b0);
        push(t_ref + 3, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(4);
        send(8'h72); push(last, 4'b0001, 1'b0, 1'b0, 1'b0);
        push(last + 3, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Time enable
        send(8'h58); push(last, 4'b0000, 1'b1, 1'b0, 1'b0);
        push(last + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Full entry committed on CR
        send(8'h23); e_busy = 1'b1; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send_str("123456");
        send(8'h0D); e_busy = 1'b0; e_bcd = 24'h123456;
        push(last, 4'b0000, 1'b0, 1'b1, 1'b0);
        push(last + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Short entry: error, value kept
        send(8'h23); e_busy = 1'b1; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send_str("12");
        send(8'h0D); e_busy = 1'b0; push(last, 4'b0000, 1'b0, 1'b0, 1'b1);
        push(last + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Command letter inside entry: error, mode untouched
        send(8'h23); e_busy = 1'b1; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send_str("12C");
        e_busy = 1'b0; push(last, 4'b0000, 1'b0, 1'b0, 1'b1);
        push(last + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Seventh digit overflows
        send(8'h23); e_busy = 1'b1; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send_str("1234567");
        e_busy = 1'b0; push(last, 4'b0000, 1'b0, 1'b0, 1'b1);
        push(last + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // LF terminator
        send(8'h23); e_busy = 1'b1; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send_str("654321");
        send(8'h0A); e_busy = 1'b0; e_bcd = 24'h654321;
        push(last, 4'b0000, 1'b0, 1'b1, 1'b0);
        push(last + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // ESC aborts silently
        send(8'h23); e_busy = 1'b1; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(8'h31);
        send(8'h1B); e_busy = 1'b0; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Silence inside an open entry
        send(8'h23); e_busy = 1'b1; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send_str("12");
        e2 = last;
`ifdef UART_CMD_TIMEOUT_EN
        e_busy = 1'b0;
        push(e2 + 50, 4'b0000, 1'b0, 1'b0, 1'b1);
        push(e2 + 51, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(60);
`else
        idle(1000);
        n_vec++;
        if (bus.oBusy !== 1'b1) begin
            n_miss++;
            $display("FAIL entry_wait busy got=%b exp=1 (from clk %0d)", bus.oBusy, e2);
        end
        send(8'h1B); e_busy = 1'b0; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
`endif
        drain();

        // Reset in the middle of an entry
        send(8'h23); e_busy = 1'b1; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        send_str("123");
        idle(2);
        drain();
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rs = sample();
        rs.c = 0;
        n_vec++;
        if (rs !== '0) begin
            n_miss++;
            $display("FAIL mid_entry_reset got=%h exp=0", rs);
        end
        e_mode = 5'b00000; e_set = 1'b0; e_busy = 1'b0; e_bcd = 24'h000000;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        send(8'h58); push(last, 4'b0000, 1'b1, 1'b0, 1'b0);
        idle(1);
        push(last + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(8'h54); e_mode = 5'b00100; push(last, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Parametrised UART command parser. Sits between the UART RX FIFO and the clock/stopwatch/sensor control logic, replacing the single-byte ASCII decoder. It keeps the single-character mode, set and FND-toggle commands. It adds true one-shot button pulses with configurable width, an explicit FIFO pop handshake, and a multi-digit numeric entry command (`#` + BCD digits + CR/LF) that loads a value such as HHMMSS into the time core.

## Interface
Parameters:
- `NUM_DIGITS`, default 6: digits required in a numeric entry; `oLoad_Bcd` width is 4*NUM_DIGITS.
- `BTN_PULSE`, default 1: button pulse width in clocks, ≥1.
- `TIMEOUT_CYC`, default 100_000_000: idle clocks before an open entry is aborted (1 s at 100 MHz).

Ports:
- `iClk`  in  1  system clock; single clock domain.
- `iRst`  in  1  asynchronous, active-high reset.
- `iRx_Data`  in  8  FIFO head byte (first-word-fall-through), valid while `iRx_Empty`=0.
- `iRx_Empty`  in  1  FIFO empty flag.
- `oRx_Pop`  out  1  FIFO read enable; byte consumed at each edge where it is 1.
- `oSet`  out  1  set-mode toggle state.
- `oMode`  out  5  {one-hot/zero mode[3:0], FND page bit}.
- `oBtn_U`, `oBtn_D`, `oBtn_L`, `oBtn_R`  out  1 each  button pulses.
- `oTime_En`  out  1  one-clock pulse on `X`.
- `oLoad`  out  1  one-clock pulse when a numeric entry commits.
- `oLoad_Bcd`  out  4*NUM_DIGITS  last committed digits, MSD first.
- `oErr`  out  1  one-clock pulse on a malformed or timed-out entry.
- `oBusy`  out  1  high while in ENTRY.

## Operation
- Handshake: `oRx_Pop` = ~`iRx_Empty`, combinational. The parser is always ready and consumes one byte per clock at most. All decoding acts on the byte consumed at that edge.
- FSM states: IDLE and ENTRY. Reset state is IDLE.
- IDLE, byte handling (case-sensitive):
  - `C`/`W`/`T`/`U`/`D` → mode[3:0] = 0000/0001/0010/0100/1000.
  - `M` → toggle the FND bit (`oMode[0]`).
  - `S` → toggle `oSet`.
  - `u`/`d`/`l`/`r` → pulse `oBtn_U`/`D`/`L`/`R` for BTN_PULSE clocks.
  - `X` → `oTime_En` pulse.
  - `#` → enter ENTRY; clear the digit counter and shift register.
  - Any other byte → ignored.
- ENTRY, byte handling:
  - `0`–`9` with count < NUM_DIGITS → shift register <<= 4, low nibble = byte−0x30, count+1.
  - `0`–`9` with count = NUM_DIGITS → `oErr`, go to IDLE.
  - CR (0x0D) or LF (0x0A) with count = NUM_DIGITS → latch the shift register into `oLoad_Bcd`, pulse `oLoad`, go to IDLE.
  - CR/LF with count < NUM_DIGITS → `oErr`, go to IDLE; `oLoad_Bcd` unchanged.
  - ESC (0x1B) → silent abort to IDLE.
  - Any other byte, including command letters → `oErr`, go to IDLE; the letter is not executed.
- Button pulses:
  - Only one button output is high at a time.
  - A new button byte during an active pulse switches to the new button and restarts the full BTN_PULSE count.
  - Non-button bytes do not affect an active pulse.
- `oErr` and `oLoad` never assert in the same cycle.

## Timing
- Every output except `oRx_Pop` is registered. Effects appear on the clock after the consuming edge, so latency is 1 clock.
- Reset values:
  - `oMode` = 0, `oSet` = 0, `oBusy` = 0.
  - All button outputs, `oTime_En`, `oLoad` and `oErr` = 0.
  - `oLoad_Bcd` = 0.
- Reset asserted mid-entry discards the partial digits. `oLoad_Bcd` goes to 0.
- Back-to-back bytes on consecutive clocks are each decoded. Nothing is dropped.
- Button outputs are high for exactly BTN_PULSE consecutive clocks unless restarted.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - A counter runs in ENTRY and clears on every consumed byte.
  - On reaching TIMEOUT_CYC−1 clocks with no byte, it pulses `oErr` and returns to IDLE next clock.
  - A byte arriving on the terminal-count edge is decoded normally and cancels the timeout.
- Not defined: no counter is built. ENTRY waits indefinitely and is left only by a byte or by reset.

## Test plan
- Reset, then bytes `T`, `M`, `S` on consecutive clocks → `oMode` = 5'b00100 then 5'b00101; `oSet` = 1; `oRx_Pop` high for exactly those 3 clocks.
- BTN_PULSE=3, send `u`, then `l` two clocks later → `oBtn_U` high for 2 clocks, then `oBtn_L` high for 3 clocks; never two buttons high together.
- `#123456`+CR → `oLoad` one pulse, `oLoad_Bcd` = 24'h123456, `oBusy` high from the clock after `#` until the clock after CR.
- `#12`+CR → `oErr` pulse, `oLoad_Bcd` keeps its previous value. `#12C` → `oErr` pulse and `oMode` unchanged.
- UART_CMD_TIMEOUT_EN with TIMEOUT_CYC=50: `#12`, then silence → `oErr` pulse about 50 clocks after `2`, `oBusy` drops. Macro undefined → no `oErr` after 1000 clocks.
- Assert `iRst` after `#123` → all outputs reach reset values. Then `X` → single `oTime_En` pulse, FSM in IDLE.
